// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo tone decoder: note/tune encodings, nominal
// periods for both FAST_SIM modes, silence timeouts and the fixed alert-tune sequences.
package piezo_pkg;

  typedef enum logic [2:0] {
    NOTE_NONE = 3'd0,
    G6        = 3'd1,
    C7        = 3'd2,
    E7        = 3'd3,
    G7        = 3'd4
  } note_t;

  typedef enum logic [1:0] {
    TUNE_NONE  = 2'd0,
    TUNE_STEER = 2'd1,
    TUNE_FAST  = 2'd2,
    TUNE_BATT  = 2'd3
  } tune_t;

  localparam logic [15:0] NOM_G6_FAST = 16'd62;
  localparam logic [15:0] NOM_C7_FAST = 16'd46;
  localparam logic [15:0] NOM_E7_FAST = 16'd37;
  localparam logic [15:0] NOM_G7_FAST = 16'd31;

  localparam logic [15:0] NOM_G6_FULL = 16'd31888;
  localparam logic [15:0] NOM_C7_FULL = 16'd23890;
  localparam logic [15:0] NOM_E7_FULL = 16'd18961;
  localparam logic [15:0] NOM_G7_FULL = 16'd15944;

  localparam logic [16:0] SIL_CYC_FAST = 17'd256;
  localparam logic [16:0] SIL_CYC_FULL = 17'd65536;

  localparam note_t STEER_SEQ [6] = '{G6, C7, E7, G7, E7, G7};
  localparam note_t BATT_SEQ  [6] = '{G7, E7, G7, E7, C7, G6};

  function automatic logic [15:0] nominal(input note_t n, input bit fast);
    logic [15:0] nom;
    case (n)
      G6:      nom = fast ? NOM_G6_FAST : NOM_G6_FULL;
      C7:      nom = fast ? NOM_C7_FAST : NOM_C7_FULL;
      E7:      nom = fast ? NOM_E7_FAST : NOM_E7_FULL;
      G7:      nom = fast ? NOM_G7_FAST : NOM_G7_FULL;
      default: nom = 16'd0;
    endcase
    return nom;
  endfunction

  // Successor in the G6 -> C7 -> E7 -> G6 cycle of the too-fast tune.
  function automatic note_t fast_succ(input note_t n);
    note_t s;
    case (n)
      G6:      s = C7;
      C7:      s = E7;
      E7:      s = G6;
      default: s = NOTE_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/piezo_period_meas.sv
// Synchronizes the piezo input, detects rising edges and measures the period between them.
// Also flags a silence pulse once no edge has been seen for the silence timeout.
module piezo_period_meas
  import piezo_pkg::*;
#(
  parameter int unsigned FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        piezo,
  output logic        lvl,
  output logic        per_vld,
  output logic [15:0] period,
  output logic        silence
);

  localparam logic [16:0] SilCyc = (FAST_SIM != 0) ? SIL_CYC_FAST : SIL_CYC_FULL;

  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q;
  logic [16:0] sil_q;
  logic        rise;

  assign rise = sync2_q & ~prev_q;
  assign lvl  = sync2_q;

  // cnt_q holds (cycles since last edge - 1), so the reported period is cnt_q + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      sil_q   <= '0;
      per_vld <= 1'b0;
      period  <= '0;
      silence <= 1'b0;
    end else begin
      sync1_q <= piezo;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      per_vld <= rise;
      silence <= 1'b0;
      if (rise) begin
        period <= (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        cnt_q  <= '0;
        sil_q  <= '0;
      end else begin
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        if (sil_q != SilCyc) sil_q <= sil_q + 17'd1;
        silence <= (sil_q == SilCyc - 17'd1);
      end
    end
  end

endmodule

// File: rtl/piezo_tone_decoder.sv
// Classifies piezo periods into notes, groups them into note events and identifies alert tunes.
// Optional complement checking of piezo_n is enabled by defining PIEZO_N_CHECK_EN.
module piezo_tone_decoder
  import piezo_pkg::*;
#(
  parameter int unsigned FAST_SIM  = 1,
  parameter int unsigned MIN_PER   = 4,
  parameter int unsigned TOL_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        piezo,
  input  logic        piezo_n,
  output logic        evt_vld,
  input  logic        evt_rdy,
  output logic [2:0]  evt_note,
  output logic [15:0] evt_len,
  output logic        evt_ovf,
  output logic        tune_vld,
  output logic [1:0]  tune_id,
  output logic        diff_err
);

  localparam bit          Fast   = (FAST_SIM != 0);
  localparam logic [15:0] MinPer = 16'(MIN_PER);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_t;

  logic        piezo_lvl, per_vld, silence;
  logic [15:0] period;

  piezo_period_meas #(
    .FAST_SIM(FAST_SIM)
  ) u_meas (
    .clk    (clk),
    .rst    (rst),
    .piezo  (piezo),
    .lvl    (piezo_lvl),
    .per_vld(per_vld),
    .period (period),
    .silence(silence)
  );

  function automatic logic in_tol(input logic [15:0] p, input logic [15:0] nom);
    logic [15:0] diff;
    diff = (p > nom) ? p - nom : nom - p;
    return diff <= (nom >> TOL_SHIFT);
  endfunction

  note_t cur_note;

  always_comb begin
    cur_note = NOTE_NONE;
    if (in_tol(period, nominal(G6, Fast)))      cur_note = G6;
    else if (in_tol(period, nominal(C7, Fast))) cur_note = C7;
    else if (in_tol(period, nominal(E7, Fast))) cur_note = E7;
    else if (in_tol(period, nominal(G7, Fast))) cur_note = G7;
  end

  state_t      state_q, state_d;
  note_t       run_note_q, run_note_d;
  logic [15:0] run_len_q, run_len_d;
  logic        term, emit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      run_note_q <= NOTE_NONE;
      run_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_note_q <= run_note_d;
      run_len_q  <= run_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_note_d = run_note_q;
    run_len_d  = run_len_q;
    term       = 1'b0;
    unique case (state_q)
      StIdle: if (per_vld) state_d = StArm;
      StArm: begin
        if (per_vld && cur_note != NOTE_NONE) begin
          state_d    = StRun;
          run_note_d = cur_note;
          run_len_d  = 16'd1;
        end else if (silence) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (per_vld) begin
          if (cur_note == run_note_q) begin
            run_len_d = (run_len_q == 16'hFFFF) ? run_len_q : run_len_q + 16'd1;
          end else begin
            term = 1'b1;
            if (cur_note == NOTE_NONE) begin
              state_d = StArm;
            end else begin
              run_note_d = cur_note;
              run_len_d  = 16'd1;
            end
          end
        end else if (silence) begin
          term    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Runs shorter than MIN_PER are glitches and never reach the event port or the tune buffer.
  assign emit = term && (run_len_q >= MinPer);

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_vld  <= 1'b0;
      evt_note <= '0;
      evt_len  <= '0;
      evt_ovf  <= 1'b0;
    end else if (emit && (!evt_vld || evt_rdy)) begin
      evt_vld  <= 1'b1;
      evt_note <= run_note_q;
      evt_len  <= run_len_q;
    end else begin
      if (evt_vld && evt_rdy) evt_vld <= 1'b0;
      if (emit) evt_ovf <= 1'b1;
    end
  end

  note_t       seq_q [6];
  logic [2:0]  seq_cnt_q;
  logic        fast_ok_q, eval_q;
  logic        steer_hit, batt_hit;
  tune_t       tune_sel;

  always_comb begin
    steer_hit = (seq_cnt_q == 3'd6);
    batt_hit  = (seq_cnt_q == 3'd6);
    for (int i = 0; i < 6; i++) begin
      if (seq_q[i] != STEER_SEQ[i]) steer_hit = 1'b0;
      if (seq_q[i] != BATT_SEQ[i])  batt_hit  = 1'b0;
    end
    if (steer_hit)                             tune_sel = TUNE_STEER;
    else if (batt_hit)                         tune_sel = TUNE_BATT;
    else if (fast_ok_q && seq_cnt_q >= 3'd3)   tune_sel = TUNE_FAST;
    else                                       tune_sel = TUNE_NONE;
  end

  // Evaluation runs the cycle after silence so the final run's note is already shifted in.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q     <= '{default: NOTE_NONE};
      seq_cnt_q <= '0;
      fast_ok_q <= 1'b0;
      eval_q    <= 1'b0;
      tune_vld  <= 1'b0;
      tune_id   <= '0;
    end else begin
      eval_q   <= silence;
      tune_vld <= 1'b0;
      if (eval_q) begin
        if (seq_cnt_q != 3'd0) begin
          tune_vld <= 1'b1;
          tune_id  <= tune_sel;
        end
        seq_cnt_q <= '0;
        fast_ok_q <= 1'b0;
      end
      if (emit) begin
        for (int i = 0; i < 5; i++) seq_q[i] <= seq_q[i+1];
        seq_q[5] <= run_note_q;
        if (seq_cnt_q != 3'd7) seq_cnt_q <= seq_cnt_q + 3'd1;
        fast_ok_q <= (seq_cnt_q == 3'd0) ? (run_note_q == G6)
                                         : (fast_ok_q && run_note_q == fast_succ(seq_q[5]));
      end
    end
  end

`ifdef PIEZO_N_CHECK_EN
  logic n_sync1_q, n_sync2_q, eq_prev_q, diff_err_q, eq_now;

  assign eq_now   = (n_sync2_q == piezo_lvl);
  assign diff_err = diff_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_sync1_q  <= 1'b0;
      n_sync2_q  <= 1'b0;
      eq_prev_q  <= 1'b0;
      diff_err_q <= 1'b0;
    end else begin
      n_sync1_q <= piezo_n;
      n_sync2_q <= n_sync1_q;
      eq_prev_q <= eq_now;
      if (eq_now && eq_prev_q) diff_err_q <= 1'b1;
    end
  end
`else
  logic unused_piezo_n;
  assign unused_piezo_n = piezo_n ^ piezo_lvl;
  assign diff_err       = 1'b0;
`endif

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Directed bench for piezo_tone_decoder (FAST_SIM=1, MIN_PER=4): table of tone sequences
// with expected events and tune, plus hand-written overflow/reset and piezo_n sequences.
module tb_piezo_tone_decoder;
  import piezo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, piezo, piezo_n, evt_rdy;
  logic        evt_vld, evt_ovf, tune_vld, diff_err;
  logic [2:0]  evt_note;
  logic [15:0] evt_len;
  logic [1:0]  tune_id;

  always #5 clk = ~clk;

  piezo_tone_decoder #(
    .FAST_SIM (1),
    .MIN_PER  (4),
    .TOL_SHIFT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .piezo   (piezo),
    .piezo_n (piezo_n),
    .evt_vld (evt_vld),
    .evt_rdy (evt_rdy),
    .evt_note(evt_note),
    .evt_len (evt_len),
    .evt_ovf (evt_ovf),
    .tune_vld(tune_vld),
    .tune_id (tune_id),
    .diff_err(diff_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Segment table: each record is a tone sequence plus the events/tune it must produce.
  typedef struct {
    int nseg;
    int per   [9];
    int cnt   [9];
    int enote [9];
    int elen  [9];
    int tune;
  } vec_t;

  vec_t vecs [7];

  task automatic add_seg(input int v, input int p, input int c, input int en, input int el);
    int k;
    k = vecs[v].nseg;
    vecs[v].per[k]   = p;
    vecs[v].cnt[k]   = c;
    vecs[v].enote[k] = en;
    vecs[v].elen[k]  = el;
    vecs[v].nseg     = k + 1;
  endtask

  int ev_note_q [$];
  int ev_len_q  [$];
  int tune_q    [$];

  initial forever begin
    @(negedge clk);
    #1;
    if (evt_vld && evt_rdy) begin
      ev_note_q.push_back(int'(evt_note));
      ev_len_q.push_back(int'(evt_len));
    end
    if (tune_vld) tune_q.push_back(int'(tune_id));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tone(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      piezo = 1'b1; piezo_n = 1'b0;
      wait_cyc(p / 2);
      piezo = 1'b0; piezo_n = 1'b1;
      wait_cyc(p - p / 2);
    end
  endtask

  // A final rising edge closes the last period of the preceding tone.
  task automatic close_edge();
    piezo = 1'b1; piezo_n = 1'b0;
    wait_cyc(4);
    piezo = 1'b0; piezo_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_evt_vld"},  evt_vld,  0);
    check({tag, "_evt_note"}, evt_note, 0);
    check({tag, "_evt_len"},  evt_len,  0);
    check({tag, "_evt_ovf"},  evt_ovf,  0);
    check({tag, "_tune_vld"}, tune_vld, 0);
    check({tag, "_tune_id"},  tune_id,  0);
    check({tag, "_diff_err"}, diff_err, 0);
  endtask

  initial begin
    int en [$];
    int el [$];
    rst = 1'b1; piezo = 1'b0; piezo_n = 1'b1; evt_rdy = 1'b1;
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(5);

    for (int v = 0; v < 7; v++) vecs[v].nseg = 0;
    add_seg(0, 62, 10, G6, 10);
    vecs[0].tune = TUNE_NONE;
    add_seg(1, 62, 8, G6, 8);  add_seg(1, 46, 8, C7, 8);  add_seg(1, 37, 8, E7, 8);
    add_seg(1, 31, 12, G7, 12); add_seg(1, 37, 4, E7, 4); add_seg(1, 31, 8, G7, 8);
    vecs[1].tune = TUNE_STEER;
    add_seg(2, 31, 8, G7, 8);  add_seg(2, 37, 4, E7, 4);  add_seg(2, 31, 12, G7, 12);
    add_seg(2, 37, 8, E7, 8);  add_seg(2, 46, 8, C7, 8);  add_seg(2, 62, 8, G6, 8);
    vecs[2].tune = TUNE_BATT;
    for (int r = 0; r < 3; r++) begin
      add_seg(3, 62, 8, G6, 8); add_seg(3, 46, 8, C7, 8); add_seg(3, 37, 8, E7, 8);
    end
    vecs[3].tune = TUNE_FAST;
    add_seg(4, 62, 8, G6, 8);  add_seg(4, 37, 3, 0, 0);   add_seg(4, 62, 8, G6, 8);
    vecs[4].tune = TUNE_NONE;
    add_seg(5, 62, 5, G6, 5);  add_seg(5, 70, 1, 0, 0);   add_seg(5, 62, 6, G6, 6);
    vecs[5].tune = TUNE_NONE;
    // Tolerance edges: 65 and 59 are both G6 and merge; 48 is the top of the C7 window.
    add_seg(6, 65, 4, 0, 0);   add_seg(6, 59, 4, G6, 8);  add_seg(6, 48, 5, C7, 5);
    vecs[6].tune = TUNE_NONE;

    for (int v = 0; v < 7; v++) begin
      ev_note_q.delete(); ev_len_q.delete(); tune_q.delete();
      en.delete(); el.delete();
      for (int s = 0; s < vecs[v].nseg; s++) begin
        tone(vecs[v].per[s], vecs[v].cnt[s]);
        if (vecs[v].elen[s] > 0) begin
          en.push_back(vecs[v].enote[s]);
          el.push_back(vecs[v].elen[s]);
        end
      end
      close_edge();
      wait_cyc(300);
      check($sformatf("v%0d_n_evt", v), ev_note_q.size(), en.size());
      for (int i = 0; i < en.size(); i++) begin
        if (i < ev_note_q.size()) begin
          check($sformatf("v%0d_evt%0d_note", v, i), ev_note_q[i], en[i]);
          check($sformatf("v%0d_evt%0d_len", v, i), ev_len_q[i], el[i]);
        end
      end
      check($sformatf("v%0d_n_tune", v), tune_q.size(), 1);
      check($sformatf("v%0d_tune_id", v), (tune_q.size() > 0) ? tune_q[0] : -1, vecs[v].tune);
      check($sformatf("v%0d_tune_hold", v), tune_id, vecs[v].tune);
      check($sformatf("v%0d_evt_vld_idle", v), evt_vld, 0);
      check($sformatf("v%0d_ovf", v), evt_ovf, 0);
    end

    // Back-pressure: first event held, second dropped, sticky overflow set.
    evt_rdy = 1'b0;
    ev_note_q.delete();
    tone(62, 8);
    tone(46, 8);
    close_edge();
    wait_cyc(300);
    check("bp_evt_vld",  evt_vld,  1);
    check("bp_evt_note", evt_note, G6);
    check("bp_evt_len",  evt_len,  8);
    check("bp_evt_ovf",  evt_ovf,  1);
    check("bp_no_accept", ev_note_q.size(), 0);

    rst = 1'b1;
    wait_cyc(1);
    check_all_zero("rst_pulse");
    rst = 1'b0;
    evt_rdy = 1'b1;
    wait_cyc(5);

    // piezo_n tied to piezo (both low) for several cycles.
    piezo = 1'b0; piezo_n = 1'b0;
    wait_cyc(6);
    piezo_n = 1'b1;
    wait_cyc(2);
`ifdef PIEZO_N_CHECK_EN
    check("diff_err_set", diff_err, 1);
`else
    check("diff_err_off", diff_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
